// File: rtl/multiplicador_param.sv
// Sequential shift-add multiplier with an internal IDLE/CALC/DONE controller.
// Operands are converted to magnitudes up front; the sign is reapplied on completion.
module multiplicador_param #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    a_reg_q, a_reg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] b_reg_q, b_reg_d;
  logic             neg_q, neg_d;

  logic             sm;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // The most negative operand negates to itself, which is its correct unsigned magnitude.
  assign sm    = signed_mode & SIGNED_EN;
  assign a_mag = (sm & a[WIDTH-1]) ? -a : a;
  assign b_mag = (sm & b[WIDTH-1]) ? -b : b;

  // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    a_reg_d = a_reg_q;
    b_reg_d = b_reg_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    prod_d  = prod_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_reg_d = {{WIDTH{1'b0}}, a_mag};
          b_reg_d = b_mag;
          acc_d   = '0;
          neg_d   = sm & (a[WIDTH-1] ^ b[WIDTH-1]);
          state_d = CALC;
        end
      end
      CALC: begin
        // Early exit: once the remaining multiplier bits are zero the sum is final.
        if (b_reg_q == '0) begin
          prod_d  = neg_q ? -acc_q : acc_q;
          state_d = DONE;
        end else begin
          if (b_reg_q[0]) acc_d = acc_q + a_reg_q;
          a_reg_d = a_reg_q << 1;
          b_reg_d = b_reg_q >> 1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      a_reg_q <= '0;
      b_reg_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_reg_q <= a_reg_d;
      b_reg_q <= b_reg_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign prod = prod_q;

endmodule

// File: tb/tb_multiplicador_param.sv
// Scoreboard bench for multiplicador_param: products are predicted by a sign-extended
// full-width multiply, latency from the magnitude of b, and handshake timing is checked directly.
module tb_multiplicador_param;

  logic        clk;
  logic        reset;
  logic        start, signed_mode;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] prod;

  logic        start1, signed_mode1;
  logic [31:0] a1, b1;
  logic        busy1, done1;
  logic [63:0] prod1;

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  logic [63:0] sb_q[$];

  multiplicador_param #(.WIDTH(32), .SIGNED_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .prod(prod)
  );

  multiplicador_param #(.WIDTH(32), .SIGNED_EN(1'b0)) u_dut_uns (
    .clk(clk), .reset(reset), .start(start1), .signed_mode(signed_mode1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .prod(prod1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_prod(input logic [31:0] x, input logic [31:0] y,
                                           input logic s);
    logic [63:0] ex, ey;
    ex = s ? {{32{x[31]}}, x} : {32'b0, x};
    ey = s ? {{32{y[31]}}, y} : {32'b0, y};
    return ex * ey;
  endfunction

  // Edges after the accepting edge until done is visible: one per significant bit of |b|, plus one.
  function automatic int exp_lat(input logic [31:0] y, input logic s);
    logic [31:0] m;
    int k;
    m = (s && y[31]) ? -y : y;
    k = 0;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
    return k + 1;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) check("prod", prod, sb_q.pop_front());
    end
  end

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                       input bit disturb);
    int n;
    @(negedge clk);
    a = ta; b = tb_v; signed_mode = ts; start = 1'b1;
    sb_q.push_back(exp_prod(ta, tb_v, ts));
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (n < 80) begin
      @(posedge clk);
      n++;
      #1;
      check("busy_op", 64'(busy), 64'd1);
      if (done) break;
      if (disturb && n == 3) begin
        a = 32'd2; b = 32'd3; signed_mode = 1'b0; start = 1'b1;
      end
      if (disturb && n == 5) start = 1'b0;
    end
    check("latency", 64'(n), 64'(exp_lat(tb_v, ts)));
    @(posedge clk);
    #1;
    check("done_pulse_end", 64'(done), 64'd0);
    check("idle_after", 64'(busy), 64'd0);
  endtask

  initial begin
    int n, seen, last_edge, cnt0;
    logic [63:0] held;

    reset = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    start1 = 1'b0; signed_mode1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_prod", prod, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    do_op(32'd3, 32'd5, 1'b0, 1'b0);
    do_op(32'hFFFFFFFF, 32'd0, 1'b0, 1'b0);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_op(-32'sd7, 32'd6, 1'b1, 1'b0);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    do_op(32'h80000000, 32'h80000000, 1'b1, 1'b0);
    do_op(32'h12345678, 32'hFFFFFFF0, 1'b1, 1'b0);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
    do_op(32'd0, 32'h80000001, 1'b1, 1'b0);

    // Reset in the middle of a long operation must abort it without a done pulse.
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_prod", prod, 64'd0);
    reset = 1'b1;
    cnt0 = done_cnt;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt), 64'(cnt0));

    // Start held high: back-to-back operations, new operand a after each completion.
    @(negedge clk);
    a = 32'd7; b = 32'd1; signed_mode = 1'b0; start = 1'b1;
    sb_q.push_back(exp_prod(32'd7, 32'd1, 1'b0));
    seen = 0; last_edge = 0; n = 0; held = '0;
    while (seen < 3 && n < 60) begin
      @(posedge clk);
      n++;
      #1;
      if (done) begin
        seen++;
        if (seen > 1) check("b2b_gap", 64'(n - last_edge), 64'd4);
        last_edge = n;
        held = prod;
        if (seen < 3) begin
          a = a + 32'd2;
          sb_q.push_back(exp_prod(a, 32'd1, 1'b0));
        end else begin
          start = 1'b0;
        end
      end else if (seen > 0) begin
        check("b2b_hold", prod, held);
      end
    end
    start = 1'b0;
    check("b2b_count", 64'(seen), 64'd3);
    repeat (3) @(posedge clk);

    // Instance with signed support disabled treats signed_mode=1 as unsigned.
    @(negedge clk);
    a1 = 32'hFFFFFFFF; b1 = 32'd2; signed_mode1 = 1'b1; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    n = 0;
    while (n < 40 && !done1) begin
      @(posedge clk);
      n++;
      #1;
    end
    check("uns_latency", 64'(n), 64'd3);
    check("uns_prod", prod1, 64'h00000001FFFFFFFE);

    repeat (2) @(posedge clk);
    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
